// File: rtl/upsample_repeat.sv
// Rate restorer: emits every input sample FACTOR times, either held or zero-stuffed,
// behind a 2-entry input FIFO and a single group register.
module upsample_repeat #(
    parameter int DW     = 8,
    parameter int FACTOR = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    input  logic          zero_ins,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_first,
    output logic          o_last
);
    localparam int CW = $clog2(FACTOR);
    localparam logic [CW-1:0] CNT_LAST = CW'(FACTOR - 1);

    // input FIFO state
    logic [DW-1:0] fifo_mem_reg [0:1];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic          full_reg;
    logic          empty_reg;
    logic          full_next;
    logic          empty_next;
    logic          i_ready_reg;

    // group register
    logic [DW-1:0] cur_data_reg;
    logic          cur_zero_reg;
    logic          cur_valid_reg;
    logic [CW-1:0] cnt_reg;

    logic in_fire;
    logic out_fire;
    logic cnt_last;
    logic cur_free;
    logic pop;
    logic bypass;
    logic push;

    assign in_fire  = i_valid & i_ready_reg & ~rst;
    assign out_fire = cur_valid_reg & o_ready & ~rst;
    assign cnt_last = (cnt_reg == CNT_LAST);
    assign cur_free = ~cur_valid_reg | (out_fire & cnt_last);

    // An idle group register takes the FIFO head first; a fresh sample only skips
    // the FIFO when nothing older is waiting.
    assign pop    = cur_free & ~empty_reg;
    assign bypass = cur_free & empty_reg & in_fire;
    assign push   = in_fire & ~bypass;

    always_comb begin
        full_next  = full_reg;
        empty_next = empty_reg;
        if (push && !pop) begin
            empty_next = 1'b0;
            full_next  = (~wr_ptr_reg == rd_ptr_reg);
        end else if (pop && !push) begin
            full_next  = 1'b0;
            empty_next = (~rd_ptr_reg == wr_ptr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_reg[wr_ptr_reg] <= i_data;
        end
    end

    // i_ready comes from next-state occupancy, so o_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            i_ready_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            full_reg    <= full_next;
            empty_reg   <= empty_next;
            i_ready_reg <= ~full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_data_reg  <= '0;
            cur_zero_reg  <= 1'b0;
            cur_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else if (cur_free) begin
            cnt_reg <= '0;
            if (pop) begin
                cur_data_reg  <= fifo_mem_reg[rd_ptr_reg];
                cur_zero_reg  <= zero_ins;
                cur_valid_reg <= 1'b1;
            end else if (bypass) begin
                cur_data_reg  <= i_data;
                cur_zero_reg  <= zero_ins;
                cur_valid_reg <= 1'b1;
            end else begin
                cur_valid_reg <= 1'b0;
            end
        end else if (out_fire) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign i_ready = i_ready_reg;
    assign o_valid = cur_valid_reg;
    assign o_data  = ((cnt_reg == '0) || !cur_zero_reg) ? cur_data_reg : '0;
    assign o_first = cur_valid_reg & (cnt_reg == '0);
    assign o_last  = cur_valid_reg & cnt_last;

endmodule

// File: tb/tb_upsample_repeat.sv
// Bench for upsample_repeat: cycle table and directed sequences at FACTOR=4,
// randomized scoreboard soak at FACTOR=3.
module tb_upsample_repeat;
    logic clk = 1'b0;
    logic rst;

    logic       iv, ir, z, ov, ordy, of, ol;
    logic [7:0] id, od;
    logic       iv3, ir3, z3, ov3, or3, of3, ol3;
    logic [7:0] id3, od3;

    always #5 clk = ~clk;

    upsample_repeat #(.DW(8), .FACTOR(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(iv), .i_ready(ir), .i_data(id), .zero_ins(z),
        .o_valid(ov), .o_ready(ordy), .o_data(od), .o_first(of), .o_last(ol)
    );

    upsample_repeat #(.DW(8), .FACTOR(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_valid(iv3), .i_ready(ir3), .i_data(id3), .zero_ins(z3),
        .o_valid(ov3), .o_ready(or3), .o_data(od3), .o_first(of3), .o_last(ol3)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       z;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic       f;
        logic       l;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    vec_t tbl[$];
    exp_t sq[$];
    int   nvec = 0;
    int   nmis = 0;
    int   nxfer = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic a_iv, input logic [7:0] a_d, input logic a_z, input logic a_or,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                       input logic e_f, input logic e_l);
        vec_t v;
        v = '{a_iv, a_d, a_z, a_or, e_ir, e_ov, e_od, e_f, e_l};
        tbl.push_back(v);
    endtask

    // Scoreboard check of one FACTOR=3 output cycle, applied before the edge.
    task automatic soak_out();
        exp_t e;
        if (ov3 && or3) begin
            if (sq.size() == 0) begin
                chk("soak_spurious_o_valid", 32'(ov3), 32'(1'b0));
            end else begin
                e = sq.pop_front();
                chk("soak_data", 32'(od3), 32'(e.d));
                chk("soak_first", 32'(of3), 32'(e.f));
                chk("soak_last", 32'(ol3), 32'(e.l));
                nxfer++;
                $display("soak xfer %0d: data=%02h first=%0d last=%0d", nxfer, od3, of3, ol3);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        int         first_ir;
        int         fourth;
        logic       fire;
        logic [7:0] got[$];
        int         exp_full_ir[6];
        exp_t       e;

        rst = 1'b1;
        iv = 1'b0; id = 8'h00; z = 1'b0; ordy = 1'b0;
        iv3 = 1'b0; id3 = 8'h00; z3 = 1'b0; or3 = 1'b0;
        @(negedge clk);
        tick();
        tick();

        chk("rst_o_valid", 32'(ov), 32'(1'b0));
        chk("rst_o_first", 32'(of), 32'(1'b0));
        chk("rst_o_last", 32'(ol), 32'(1'b0));
        chk("rst_o_data", 32'(od), 32'(8'h00));
        chk("rst_i_ready", 32'(ir), 32'(1'b0));
        chk("rst_i_ready_f3", 32'(ir3), 32'(1'b0));
        rst = 1'b0;
        tick();
        chk("rst_release_i_ready", 32'(ir), 32'(1'b1));
        chk("rst_release_o_valid", 32'(ov), 32'(1'b0));

        // repeat mode, back-to-back groups
        add(1, 8'h11, 0, 1,  1, 0, 8'h00, 0, 0);
        add(1, 8'h22, 0, 1,  1, 1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h11, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h11, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h11, 0, 1);
        add(0, 8'h00, 0, 1,  1, 1, 8'h22, 1, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h22, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h22, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h22, 0, 1);
        // zero-stuff, mode flipped mid-group
        add(1, 8'hA5, 1, 1,  1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'hA5, 1, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h00, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h00, 0, 1);
        add(1, 8'h3C, 0, 1,  1, 0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 1,  1, 1, 8'h3C, 1, 0);
        add(0, 8'h00, 1, 1,  1, 1, 8'h3C, 0, 0);
        add(0, 8'h00, 1, 1,  1, 1, 8'h3C, 0, 0);
        // push while group ends with FIFO empty: bypass, no bubble
        add(1, 8'h5A, 0, 1,  1, 1, 8'h3C, 0, 1);
        // backpressure 1,0,0,1,...
        add(0, 8'h00, 1, 1,  1, 1, 8'h5A, 1, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 1,  1, 1, 8'h5A, 0, 0);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 1);
        add(0, 8'h00, 0, 0,  1, 1, 8'h5A, 0, 1);
        add(0, 8'h00, 0, 1,  1, 1, 8'h5A, 0, 1);
        add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0);

        foreach (tbl[k]) begin
            iv = tbl[k].iv; id = tbl[k].d; z = tbl[k].z; ordy = tbl[k].ordy;
            chk($sformatf("tbl%0d_i_ready", k), 32'(ir), 32'(tbl[k].ir));
            chk($sformatf("tbl%0d_o_valid", k), 32'(ov), 32'(tbl[k].ov));
            chk($sformatf("tbl%0d_o_first", k), 32'(of), 32'(tbl[k].f));
            chk($sformatf("tbl%0d_o_last", k), 32'(ol), 32'(tbl[k].l));
            if (tbl[k].ov) begin
                chk($sformatf("tbl%0d_o_data", k), 32'(od), 32'(tbl[k].od));
            end
            $display("vec %0d: iv=%0d d=%02h z=%0d ordy=%0d -> ir=%0d ov=%0d od=%02h f=%0d l=%0d",
                     k, iv, id, z, ordy, ir, ov, od, of, ol);
            tick();
        end
        iv = 1'b0;

        // FIFO full: only 3 of 4 samples accepted while o_ready is low
        exp_full_ir = '{1, 1, 1, 0, 0, 0};
        ordy = 1'b0; z = 1'b0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            iv = (acc < 4); id = 8'(acc + 1);
            chk($sformatf("full_i_ready_%0d", k), 32'(ir), 32'(exp_full_ir[k]));
            fire = iv & ir;
            tick();
            if (fire) acc++;
        end
        chk("full_accepted", 32'(acc), 32'(3));

        ordy = 1'b1; first_ir = -1; fourth = -1;
        for (int c = 0; c < 60 && got.size() < 16; c++) begin
            iv = (acc < 4); id = 8'(acc + 1);
            if (ir && first_ir < 0) first_ir = c;
            if (ov) begin
                got.push_back(od);
                if (got.size() == 4) fourth = c;
            end
            fire = iv & ir;
            tick();
            if (fire) acc++;
        end
        iv = 1'b0;
        chk("full_xfer_count", 32'(got.size()), 32'(16));
        chk("full_first_group_end", 32'(fourth), 32'(3));
        chk("full_ready_return", 32'(first_ir), 32'(4));
        foreach (got[k]) begin
            chk($sformatf("full_order_%0d", k), 32'(got[k]), 32'(k / 4 + 1));
        end
        chk("full_drained", 32'(ov), 32'(1'b0));

        // reset mid-group with two samples queued
        ordy = 1'b0; acc = 0;
        for (int k = 0; k < 4; k++) begin
            iv = (acc < 3); id = 8'(8'h40 + acc);
            fire = iv & ir;
            tick();
            if (fire) acc++;
        end
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        tick();
        chk("midrst_pre_data", 32'(od), 32'(8'h40));
        chk("midrst_pre_first", 32'(of), 32'(1'b0));
        rst = 1'b1;
        tick();
        chk("midrst_o_valid", 32'(ov), 32'(1'b0));
        chk("midrst_i_ready", 32'(ir), 32'(1'b0));
        chk("midrst_o_data", 32'(od), 32'(8'h00));
        chk("midrst_o_first", 32'(of), 32'(1'b0));
        chk("midrst_o_last", 32'(ol), 32'(1'b0));
        rst = 1'b0;
        tick();
        chk("midrst_release_i_ready", 32'(ir), 32'(1'b1));
        chk("midrst_release_o_valid", 32'(ov), 32'(1'b0));
        iv = 1'b1; id = 8'h7E; z = 1'b0;
        tick();
        iv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst_7e_valid_%0d", k), 32'(ov), 32'(1'b1));
            chk($sformatf("midrst_7e_data_%0d", k), 32'(od), 32'(8'h7E));
            chk($sformatf("midrst_7e_first_%0d", k), 32'(of), 32'(k == 0));
            chk($sformatf("midrst_7e_last_%0d", k), 32'(ol), 32'(k == 3));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_no_leftover_%0d", k), 32'(ov), 32'(1'b0));
            tick();
        end

        // randomized soak at FACTOR=3: hold phase, then zero-stuff phase
        for (int ph = 0; ph < 2; ph++) begin
            z3 = ph[0];
            for (int c = 0; c < 400; c++) begin
                iv3 = 1'($urandom_range(0, 1));
                id3 = 8'($urandom);
                or3 = ($urandom_range(0, 3) != 0);
                chk("soak_no_x", 32'($isunknown({ov3, od3, of3, ol3, ir3})), 32'(0));
                soak_out();
                if (iv3 && ir3) begin
                    for (int r = 0; r < 3; r++) begin
                        e.d = (r == 0 || !z3) ? id3 : 8'h00;
                        e.f = (r == 0);
                        e.l = (r == 2);
                        sq.push_back(e);
                    end
                end
                tick();
            end
            iv3 = 1'b0; or3 = 1'b1;
            for (int c = 0; c < 100 && sq.size() > 0; c++) begin
                soak_out();
                tick();
            end
            chk("soak_drained", 32'(sq.size()), 32'(0));
            chk("soak_idle", 32'(ov3), 32'(1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/upsample_repeat.md
Name: upsample_repeat

Overview:
- Stream stage directly downstream of the downsampler. Consumes its decimated sample stream and restores the original rate by emitting each input sample FACTOR times, either held (repeat) or zero-stuffed.
- Valid/ready on both sides, with a 2-entry input FIFO and a 1-entry output group register.
- Sustains back-to-back groups with no bubble.

Parameters:
- DW, 8, sample width in bits.
- FACTOR, 4, output samples per input sample; legal range 2..256.
- CW, $clog2(FACTOR), width of the group counter; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- i_valid  in  1  upstream sample valid.
- i_ready  out  1  upstream may transfer; registered, equals FIFO-not-full.
- i_data  in  DW  upstream sample.
- zero_ins  in  1  mode: 1 = zero-stuff, 0 = hold-repeat; sampled when a sample is loaded into the group register.
- o_valid  out  1  output sample valid.
- o_ready  in  1  downstream accepts.
- o_data  out  DW  output sample.
- o_first  out  1  high on the first sample of each group (cnt==0).
- o_last  out  1  high on the final sample of each group (cnt==FACTOR-1).

Behaviour:
- Handshakes:
  - Input transfer = i_valid & i_ready at posedge.
  - Output transfer = o_valid & o_ready at posedge.
  - i_valid must not depend on i_ready.
- Reset (rst=1 at posedge):
  - FIFO emptied, cnt=0, cur_valid=0.
  - Outputs: o_valid=0, o_first=0, o_last=0, o_data=0.
  - i_ready=0 while rst is high; i_ready=1 in the first cycle after rst falls.
  - Handshakes presented while rst=1 are ignored.
- Storage:
  - FIFO depth 2, pointers wrap mod 2, separate full/empty flags.
  - Group register holds cur_data, cur_zero (latched zero_ins), cur_valid, and cnt[CW-1:0].
- Output mapping:
  - o_valid = cur_valid.
  - o_data = cur_data when cnt==0, or when cnt>0 and cur_zero==0; otherwise 0.
  - o_first = cur_valid & (cnt==0).
  - o_last = cur_valid & (cnt==FACTOR-1).
- Counter:
  - On an output transfer with cnt<FACTOR-1: cnt+1.
  - On an output transfer with cnt==FACTOR-1: cnt←0 and the group ends.
  - Without an output transfer, o_data/o_first/o_last/o_valid hold stable.
- Loading the group register happens when the register is free: cur_valid==0, or the group ends this cycle.
  - FIFO non-empty: pop the head into cur_data and latch zero_ins into cur_zero.
  - FIFO empty and input transfer this cycle: bypass i_data directly into cur_data, skipping the FIFO.
  - Neither: cur_valid←0.
- Latency and throughput:
  - Bypass latency is 1 cycle: a sample accepted at edge t is presented with o_valid=1 after edge t.
  - Steady-state throughput is 1 input per FACTOR cycles with o_ready held high, with no idle cycle between groups.
- i_ready is registered: full is computed from next-state occupancy, so there is no combinational path o_ready→i_ready.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - When the FIFO is full, i_ready=0 even if a pop occurs this cycle; i_ready rises the following cycle.
- Simultaneous push and pop with the FIFO empty and the group ending: input bypasses into cur, the FIFO stays empty.
- zero_ins changes mid-group have no effect until the next load.
- Reset mid-group: the group is abandoned immediately. There is no partial completion and no pending sample survives.
- FACTOR=2: cnt is 1 bit; o_first and o_last alternate.

Test Plan:
- Repeat mode: FACTOR=4, zero_ins=0, o_ready=1, push 0x11 then 0x22 back-to-back.
  -> o_data 11,11,11,11,22,22,22,22 on 8 consecutive cycles.
  -> o_first on the 1st and 5th, o_last on the 4th and 8th.
  -> first o_valid 1 cycle after the 0x11 acceptance.
- Zero-stuff: zero_ins=1, push 0xA5. -> o_data A5,00,00,00.
  - Flip zero_ins to 0 during the group. -> no change until the next sample.
- Backpressure: o_ready toggling 1,0,0,1,... during a group.
  -> o_data, o_first and o_last hold while o_ready=0.
  -> exactly 4 transfers per sample, no sample lost or duplicated.
- FIFO full: o_ready=0, push 4 samples 0x01..0x04.
  -> 3 accepted (1 in cur, 2 in FIFO), then i_ready=0.
  - Raise o_ready. -> i_ready returns 1 one cycle after the first group ends.
  - Output order is 01,02,03 each ×4, followed by 04 ×4.
- Reset mid-group: assert rst at cnt==2 with 2 samples queued.
  -> next cycle o_valid=0, i_ready=0.
  - After rst falls, push 0x7E. -> output starts cleanly at cnt 0 with 7E.
- Random soak: random i_valid/o_ready, FACTOR=3.
  -> scoreboard confirms every input appears exactly 3× in order.
  -> o_first/o_last pattern consistent; no X on outputs after reset.
